dma_arbiter: RTL

DMA_ARBITER -- requirements
Module: dma_arbiter

---
 rtl/dma_arb_pkg.sv | 19 +
 rtl/dma_arbiter_if.sv | 33 +++
 rtl/dma_arbiter_rr_select.sv | 29 ++
 rtl/dma_arbiter.sv | 92 +++++++++
 4 files changed

// File: rtl/dma_arb_pkg.sv
// Shared types and defaults for the DMA arbiter slice.
package dma_arb_pkg;

  localparam int DEFAULT_NUM_REQ           = 3;
  localparam int DEFAULT_MEM_ADDRESS_WIDTH = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  // Keeps the owner index at least one bit wide even for a single requester.
  function automatic int owner_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dma_arbiter_if.sv
// Requester and DMA-engine signals of the arbiter; slave is the arbiter's view.
interface dma_arbiter_if
  import dma_arb_pkg::*;
#(
  parameter int NUM_REQ           = DEFAULT_NUM_REQ,
  parameter int MEM_ADDRESS_WIDTH = DEFAULT_MEM_ADDRESS_WIDTH
);

  localparam int OWNER_WIDTH = owner_width(NUM_REQ);

  logic [NUM_REQ-1:0]                         i_req;
  logic [NUM_REQ-1:0][MEM_ADDRESS_WIDTH-1:0]  i_req_addr;
  logic [NUM_REQ-1:0][MEM_ADDRESS_WIDTH-1:0]  i_req_count;
  logic [NUM_REQ-1:0]                         o_grant;
  logic [NUM_REQ-1:0]                         o_done;
  logic                                       o_dma_read;
  logic [MEM_ADDRESS_WIDTH-1:0]               o_dma_address;
  logic [MEM_ADDRESS_WIDTH-1:0]               o_dma_count;
  logic                                       i_dma_ready;
  logic                                       o_busy;
  logic [OWNER_WIDTH-1:0]                     o_owner;

  modport master (
    output i_req, i_req_addr, i_req_count, i_dma_ready,
    input  o_grant, o_done, o_dma_read, o_dma_address, o_dma_count, o_busy, o_owner
  );

  modport slave (
    input  i_req, i_req_addr, i_req_count, i_dma_ready,
    output o_grant, o_done, o_dma_read, o_dma_address, o_dma_count, o_busy, o_owner
  );

endinterface

// File: rtl/dma_arbiter_rr_select.sv
// Combinational round-robin picker: first set request at or after the start index.
module rr_select
  import dma_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEFAULT_NUM_REQ,
  parameter int OWNER_WIDTH = owner_width(DEFAULT_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]     req,
  input  logic [OWNER_WIDTH-1:0] start,
  output logic                   valid,
  output logic [OWNER_WIDTH-1:0] winner
);

  logic [OWNER_WIDTH-1:0] pick;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    pick   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pick = OWNER_WIDTH'((int'(start) + i) % NUM_REQ);
      if (!valid && req[pick]) begin
        valid  = 1'b1;
        winner = pick;
      end
    end
  end

endmodule

// File: rtl/dma_arbiter.sv
// Shares one DMA engine among NUM_REQ requesters with round-robin arbitration.
module dma_arbiter
  import dma_arb_pkg::*;
#(
  parameter int NUM_REQ           = DEFAULT_NUM_REQ,
  parameter int MEM_ADDRESS_WIDTH = DEFAULT_MEM_ADDRESS_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  dma_arbiter_if.slave  bus
);

  localparam int OW = owner_width(NUM_REQ);

  arb_state_e                   state_q, state_d;
  logic [OW-1:0]                owner_q, owner_d;
  logic [OW-1:0]                ptr_q, ptr_d;
  logic [MEM_ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [MEM_ADDRESS_WIDTH-1:0] count_q, count_d;
  logic [NUM_REQ-1:0]           grant_q, grant_d;
  logic [NUM_REQ-1:0]           done_vec;
  logic                         sel_valid;
  logic [OW-1:0]                sel_idx;

  rr_select #(
    .NUM_REQ     (NUM_REQ),
    .OWNER_WIDTH (OW)
  ) u_rr_select (
    .req    (bus.i_req),
    .start  (ptr_q),
    .valid  (sel_valid),
    .winner (sel_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      count_q <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    count_d = count_q;
    grant_d = '0;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          owner_d          = sel_idx;
          ptr_d            = (int'(sel_idx) == NUM_REQ - 1) ? '0 : OW'(sel_idx + 1'b1);
          addr_d           = bus.i_req_addr[sel_idx];
          count_d          = bus.i_req_count[sel_idx];
          grant_d[sel_idx] = 1'b1;
          // A zero-length request completes without ever touching the engine.
          state_d          = (bus.i_req_count[sel_idx] == '0) ? DONE : ISSUE;
        end
      end
      ISSUE:   state_d = WAIT;
      WAIT:    if (bus.i_dma_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    done_vec = '0;
    if (state_q == DONE) done_vec[owner_q] = 1'b1;
  end

  assign bus.o_grant       = grant_q;
  assign bus.o_done        = done_vec;
  assign bus.o_dma_read    = (state_q == ISSUE);
  assign bus.o_dma_address = addr_q;
  assign bus.o_dma_count   = count_q;
  assign bus.o_busy        = (state_q != IDLE);
  assign bus.o_owner       = owner_q;

endmodule
